// File: rtl/layernorm_stats_accum.sv
// LayerNorm statistics accumulator.
// Sums N_CHUNKS (partial sum, partial square sum) pairs from the 64-lane adder
// tree into one token vector. It then produces the mean, E[x^2] and the
// variance in Q.8 through a 4-stage pipeline. The pipeline accepts one
// completed vector per cycle.
//
// stage    | meaning
// ---------+-------------------------------------------------------------
// accum    | acc_s/acc_q/cnt collect chunks; snapshot tot_s/tot_q on last
// P1       | ps/pq = totals * RECIP (reciprocal of element count)
// P2       | round-half-up >>> 16 to Q.8 mean and E[x^2]
// P3       | msq = mean^2 >> 8, mean/ex2 delayed alongside
// P4       | var = ex2 - msq clamped at 0, outputs registered, o_valid

module layernorm_stats_accum #(
   parameter int N_CHUNKS = 12
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [21:0] i_part_sum,
   input  logic [37:0] i_part_sq_sum,
   input  logic        i_flush,
   output logic        o_valid,
   output logic [23:0] o_mean,
   output logic [39:0] o_ex2,
   output logic [39:0] o_var,
   output logic        o_busy
);

   localparam int N_ELEMS = 64 * N_CHUNKS;
   // Reciprocal rounded to nearest; it is scaled by 2^24, so >>16 leaves Q.8.
   localparam logic [19:0] RECIP = 20'((2 ** 24 + N_ELEMS / 2) / N_ELEMS);
   localparam logic signed [20:0] RECIP_S = $signed({1'b0, RECIP});
   localparam logic [3:0] LAST = 4'(N_CHUNKS - 1);

   logic signed [25:0] acc_s;
   logic signed [41:0] acc_q;
   logic [3:0]         cnt;
   logic signed [25:0] sum_ext;
   logic signed [41:0] sq_ext;
   logic               last_chunk;

   logic signed [25:0] tot_s;
   logic signed [41:0] tot_q;
   logic               v0;

   logic signed [45:0] ps;
   logic signed [61:0] pq;
   logic               v1;

   logic signed [23:0] mean;
   logic [39:0]        ex2;
   logic               v2;

   logic signed [23:0] mean_d;
   logic [39:0]        ex2_d;
   logic [39:0]        msq;
   logic               v3;

   assign sum_ext    = {{4{i_part_sum[21]}}, i_part_sum};
   assign sq_ext     = {{4{i_part_sq_sum[37]}}, i_part_sq_sum};
   // Flush wins over a coincident chunk, so the chunk never closes a vector.
   assign last_chunk = i_valid && !i_flush && (cnt == LAST);

   // Chunk accumulation; the last chunk clears state so vectors can abut.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         acc_s  <= '0;
         acc_q  <= '0;
         cnt    <= '0;
         o_busy <= 1'b0;
      end else if (i_valid) begin
         if (cnt == LAST) begin
            acc_s <= '0;
            acc_q <= '0;
            cnt   <= '0;
         end else begin
            acc_s <= acc_s + sum_ext;
            acc_q <= acc_q + sq_ext;
            cnt   <= cnt + 4'd1;
         end
         // Mirrors the next value of cnt being nonzero.
         o_busy <= (cnt != LAST);
      end
   end

   // Snapshot of the completed vector totals.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tot_s <= '0;
         tot_q <= '0;
         v0    <= 1'b0;
      end else begin
         v0 <= last_chunk;
         if (last_chunk) begin
            tot_s <= acc_s + sum_ext;
            tot_q <= acc_q + sq_ext;
         end
      end
   end

   // P1: scale totals by the reciprocal of the element count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ps <= '0;
         pq <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= v0;
         if (v0) begin
            ps <= 46'(tot_s) * 46'(RECIP_S);
            pq <= 62'(tot_q) * 62'(RECIP_S);
         end
      end
   end

   // P2: round half up and drop to Q.8.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mean <= '0;
         ex2  <= '0;
         v2   <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            mean <= 24'((ps + 46'sd32768) >>> 16);
            ex2  <= 40'((pq + 62'sd32768) >>> 16);
         end
      end
   end

   // P3: square of the mean, rescaled back to Q.8.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mean_d <= '0;
         ex2_d  <= '0;
         msq    <= '0;
         v3     <= 1'b0;
      end else begin
         v3 <= v2;
         if (v2) begin
            mean_d <= mean;
            ex2_d  <= ex2;
            msq    <= 40'((48'(mean) * 48'(mean)) >> 8);
         end
      end
   end

   // P4: variance with clamp against rounding going negative; outputs hold when idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_mean  <= '0;
         o_ex2   <= '0;
         o_var   <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= v3;
         if (v3) begin
            o_mean <= mean_d;
            o_ex2  <= ex2_d;
            o_var  <= (ex2_d >= msq) ? (ex2_d - msq) : '0;
         end
      end
   end

endmodule

// File: tb/tb_layernorm_stats_accum.sv
// Directed bench for layernorm_stats_accum with N_CHUNKS = 12.
module tb_layernorm_stats_accum;

   localparam int N = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [21:0] part_sum;
   logic [37:0] part_sq;
   logic        flush;
   logic        o_valid;
   logic [23:0] o_mean;
   logic [39:0] o_ex2;
   logic [39:0] o_var;
   logic        o_busy;

   layernorm_stats_accum #(.N_CHUNKS(N)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_valid       (valid),
      .i_part_sum    (part_sum),
      .i_part_sq_sum (part_sq),
      .i_flush       (flush),
      .o_valid       (o_valid),
      .o_mean        (o_mean),
      .o_ex2         (o_ex2),
      .o_var         (o_var),
      .o_busy        (o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string  name;
      int     sum;
      longint sq;
      int     gap;
      longint e_mean;
      longint e_ex2;
      longint e_var;
   } vec_t;

   typedef struct {
      int     cyc;
      longint mean;
      longint ex2;
      longint var_v;
   } pulse_t;

   pulse_t pulses[$];
   int     cyc = 0;
   int     n_checks = 0;
   int     n_pass = 0;

   // Log every output pulse with the edge number it followed.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (o_valid)
         pulses.push_back('{cyc, longint'($signed(o_mean)), longint'(o_ex2), longint'(o_var)});
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_chunk(input int s, input longint q);
      valid    = 1'b1;
      part_sum = 22'(s);
      part_sq  = 38'(q);
      tick();
      valid = 1'b0;
   endtask

   task automatic send_vector(input int s, input longint q, input int gap, output int last_cyc);
      for (int i = 0; i < N; i++) begin
         send_chunk(s, q);
         for (int g = 0; g < gap && i < N - 1; g++) tick();
      end
      last_cyc = cyc;
   endtask

   task automatic drain();
      repeat (8) tick();
   endtask

   task automatic check_pulse(input string name, input int idx, input int ref_cyc, input int lat,
                              input longint em, input longint eq, input longint ev);
      if (pulses.size() > idx) begin
         check({name, " latency"}, pulses[idx].cyc - ref_cyc, lat);
         check({name, " mean"}, pulses[idx].mean, em);
         check({name, " ex2"}, pulses[idx].ex2, eq);
         check({name, " var"}, pulses[idx].var_v, ev);
      end
   endtask

   vec_t tbl[6];
   int   last, last2;

   initial begin
      tbl[0] = '{"ones",      64,  64,  0, 256,  256,  0};
      tbl[1] = '{"neg2",    -128, 256,  0, -512, 1024, 0};
      tbl[2] = '{"alt2_gap",   0, 256,  2, 0,    1024, 1024};
      tbl[3] = '{"frac",     100, 300,  0, 400,  1200, 575};
      tbl[4] = '{"neg_frac", -37, 500,  1, -148, 2000, 1915};
      tbl[5] = '{"clamp",     64,   0,  0, 256,  0,    0};

      rst = 1'b1; valid = 1'b0; flush = 1'b0; part_sum = '0; part_sq = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset valid", longint'(o_valid), 0);
      check("reset mean", longint'(o_mean), 0);
      check("reset ex2", longint'(o_ex2), 0);
      check("reset var", longint'(o_var), 0);
      check("reset busy", longint'(o_busy), 0);

      foreach (tbl[r]) begin
         pulses.delete();
         send_vector(tbl[r].sum, tbl[r].sq, tbl[r].gap, last);
         drain();
         check({tbl[r].name, " pulses"}, pulses.size(), 1);
         check_pulse(tbl[r].name, 0, last, 4, tbl[r].e_mean, tbl[r].e_ex2, tbl[r].e_var);
         check({tbl[r].name, " busy_after"}, longint'(o_busy), 0);
         check({tbl[r].name, " valid_low"}, longint'(o_valid), 0);
      end

      // Two vectors on 24 consecutive valid cycles.
      pulses.delete();
      send_vector(64, 64, 0, last);
      send_vector(-128, 256, 0, last2);
      drain();
      check("b2b pulses", pulses.size(), 2);
      check_pulse("b2b first", 0, last, 4, 256, 256, 0);
      check_pulse("b2b second", 1, last2, 4, -512, 1024, 0);
      if (pulses.size() == 2)
         check("b2b spacing", pulses[1].cyc - pulses[0].cyc, N);

      // Interrupted vector: flush coincident with a chunk drops it.
      pulses.delete();
      for (int i = 0; i < 5; i++) send_chunk(64, 64);
      check("flush busy_before", longint'(o_busy), 1);
      valid = 1'b1; flush = 1'b1; part_sum = 22'(64); part_sq = 38'(64);
      tick();
      valid = 1'b0; flush = 1'b0;
      check("flush busy_after", longint'(o_busy), 0);
      send_vector(64, 64, 0, last);
      drain();
      check("flush pulses", pulses.size(), 1);
      check_pulse("flush vec", 0, last, 4, 256, 256, 0);
      check("flush busy_end", longint'(o_busy), 0);

      // Reset after 7 chunks loses the partial vector and clears outputs.
      pulses.delete();
      for (int i = 0; i < 7; i++) send_chunk(-128, 256);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drain();
      check("rst7 pulses", pulses.size(), 0);
      check("rst7 mean", longint'(o_mean), 0);
      check("rst7 ex2", longint'(o_ex2), 0);
      check("rst7 var", longint'(o_var), 0);
      check("rst7 busy", longint'(o_busy), 0);
      send_vector(64, 64, 0, last);
      drain();
      check("rst7 next pulses", pulses.size(), 1);
      check_pulse("rst7 next", 0, last, 4, 256, 256, 0);

      // Reset while a completed vector is still in the pipeline.
      pulses.delete();
      send_vector(-128, 256, 0, last);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drain();
      check("rst_inflight pulses", pulses.size(), 0);
      check("rst_inflight mean", longint'(o_mean), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
